// File: rtl/mdio_controller_if.sv
// rtl/mdio_controller_if.sv - host-side request/response bundle for mdio_controller
interface mdio_controller_if;
    logic        i_mdio_start;
    logic [31:0] i_t_data;
    logic        o_busy;
    logic [15:0] o_rd_data;
    logic        o_data_rdy;

    modport master (
        output i_mdio_start,
        output i_t_data,
        input  o_busy,
        input  o_rd_data,
        input  o_data_rdy
    );

    modport slave (
        input  i_mdio_start,
        input  i_t_data,
        output o_busy,
        output o_rd_data,
        output o_data_rdy
    );
endinterface

// File: rtl/mdio_controller.sv
// rtl/mdio_controller.sv - MDIO management-side frame serializer/deserializer; optional MDIO_PREAMBLE_EN adds a 32-bit all-ones preamble
module mdio_controller #(
    parameter int unsigned MDC_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mdio_controller_if.slave  bus,
    input  logic              i_mdio_in,
    output logic              o_mdc,
    output logic              o_mdio_oe,
    output logic              o_mdio_out
);

`ifdef MDIO_PREAMBLE_EN
    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_FRAME} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FRAME} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(MDC_DIV - 1);

    state_t      r_state;
    logic [31:0] r_frame;
    logic        r_is_read;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_div_cnt;
    logic        r_high;
    logic [14:0] r_rx;
    logic        r_mdc;
    logic        r_oe;
    logic        r_out;
    logic [15:0] r_rd_data;
    logic        r_data_rdy;
    logic        r_busy;

    logic        w_div_end;
    logic [4:0]  w_next_cnt;
    logic        w_read_bit;
    logic        w_next_rd_bit;

    // Phase boundary and the turnaround decision for the current and following bit
    assign w_div_end     = (r_div_cnt == DIV_LAST);
    assign w_next_cnt    = r_bit_cnt - 5'd1;
    assign w_read_bit    = r_is_read && !r_bit_cnt[4];
    assign w_next_rd_bit = r_is_read && !w_next_cnt[4];

    // Controller FSM: every output is registered so MDC/MDIO edges line up with CLK
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_is_read  <= 1'b0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_high     <= 1'b0;
            r_rx       <= '0;
            r_mdc      <= 1'b0;
            r_oe       <= 1'b0;
            r_out      <= 1'b0;
            r_rd_data  <= '0;
            r_data_rdy <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_data_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_mdio_start) begin
                        r_frame   <= bus.i_t_data;
                        r_is_read <= (bus.i_t_data[29:28] == 2'b10);
                        r_bit_cnt <= 5'd31;
                        r_div_cnt <= '0;
                        r_high    <= 1'b0;
                        r_mdc     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_oe      <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
                        r_state   <= S_PREAMBLE;
                        r_out     <= 1'b1;
`else
                        r_state   <= S_FRAME;
                        r_out     <= bus.i_t_data[31];
`endif
                    end
                end
`ifdef MDIO_PREAMBLE_EN
                S_PREAMBLE: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_high    <= !r_high;
                        r_mdc     <= !r_high;
                        if (r_high) begin
                            if (r_bit_cnt == 5'd0) begin
                                r_state   <= S_FRAME;
                                r_bit_cnt <= 5'd31;
                                r_out     <= r_frame[31];
                            end else begin
                                r_bit_cnt <= w_next_cnt;
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
`endif
                S_FRAME: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_high    <= !r_high;
                        r_mdc     <= !r_high;
                        if (r_high) begin
                            // Last CLK of the high phase: the peripheral's bit is settled here
                            if (w_read_bit) begin
                                r_rx <= {r_rx[13:0], i_mdio_in};
                            end
                            if (r_bit_cnt == 5'd0) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_oe    <= 1'b0;
                                r_out   <= 1'b0;
                                if (r_is_read) begin
                                    r_rd_data  <= {r_rx, i_mdio_in};
                                    r_data_rdy <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= w_next_cnt;
                                r_oe      <= !w_next_rd_bit;
                                r_out     <= w_next_rd_bit ? 1'b0 : r_frame[w_next_cnt];
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mdc          = r_mdc;
    assign o_mdio_oe      = r_oe;
    assign o_mdio_out     = r_out;
    assign bus.o_busy     = r_busy;
    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_data_rdy = r_data_rdy;

endmodule

// File: tb/tb_mdio_controller.sv
// tb/tb_mdio_controller.sv - directed vector bench for mdio_controller
module tb_mdio_controller;

    localparam int D = 2;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE     = 64 * D;
    localparam int PRE_BIT = 32;
`else
    localparam int PRE     = 0;
    localparam int PRE_BIT = 0;
`endif
    localparam int END_CYC = 1 + 64 * D + PRE;

    typedef struct {
        logic [31:0] t_data;
        logic [15:0] phy_rd;
        logic        restart;
        logic        is_read;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
    } vec_t;

    logic clk;
    logic i_reset;
    logic i_mdio_in;
    logic o_mdc;
    logic o_mdio_oe;
    logic o_mdio_out;

    mdio_controller_if bus();

    mdio_controller #(.MDC_DIV(D)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .bus        (bus),
        .i_mdio_in  (i_mdio_in),
        .o_mdc      (o_mdc),
        .o_mdio_oe  (o_mdio_oe),
        .o_mdio_out (o_mdio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_rd;
    vec_t        vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called right after a negedge; the next posedge is cycle 0
    task automatic run_frame(input int idx, input vec_t v);
        logic [63:0] cap_out;
        logic [63:0] cap_oe;
        logic [63:0] exp_o;
        logic [63:0] exp_e;
        int rises, first_rise, oe_fall, done_cyc, rdy_cnt, rdy_cyc;
        logic prev_mdc, prev_oe, prev_busy;
        int f, k, exp_fall;
        cap_out = '0; cap_oe = '0;
        rises = 0; first_rise = -1; oe_fall = -1; done_cyc = -1;
        rdy_cnt = 0; rdy_cyc = -1;
        prev_mdc = 1'b0; prev_oe = 1'b0; prev_busy = 1'b0;
        bus.i_mdio_start = 1'b1;
        bus.i_t_data     = v.t_data;
        @(posedge clk);
        #1;
        bus.i_mdio_start = 1'b0;
        bus.i_t_data     = ~v.t_data;
        for (int cyc = 1; cyc <= END_CYC + 4; cyc++) begin
            @(negedge clk);
            if (o_mdc && !prev_mdc) begin
                if (first_rise < 0) first_rise = cyc;
                cap_out = {cap_out[62:0], o_mdio_out};
                cap_oe  = {cap_oe[62:0], o_mdio_oe};
                f = rises - PRE_BIT;
                k = 31 - f;
                i_mdio_in = (f >= 0 && k <= 15) ? v.phy_rd[k] : 1'b0;
                rises++;
            end
            if (prev_oe && !o_mdio_oe && oe_fall < 0) oe_fall = cyc;
            if (prev_busy && !bus.o_busy && done_cyc < 0) begin
                done_cyc = cyc;
                check($sformatf("v%0d end mdc/oe/out", idx), {o_mdc, o_mdio_oe, o_mdio_out}, 3'b000);
            end
            if (bus.o_data_rdy) begin
                rdy_cnt++;
                rdy_cyc = cyc;
            end
            prev_mdc = o_mdc; prev_oe = o_mdio_oe; prev_busy = bus.o_busy;
            if (v.restart && cyc == 39) begin
                bus.i_mdio_start = 1'b1;
                bus.i_t_data     = 32'h5AAA_AAAA;
            end
            if (cyc == 40) bus.i_mdio_start = 1'b0;
        end
        i_mdio_in = 1'b0;
        exp_o = (PRE_BIT != 0) ? {32'hFFFF_FFFF, v.exp_out} : {32'h0, v.exp_out};
        exp_e = (PRE_BIT != 0) ? {32'hFFFF_FFFF, v.exp_oe}  : {32'h0, v.exp_oe};
        exp_fall = v.is_read ? (1 + 32 * D + PRE) : END_CYC;
        if (v.is_read) exp_rd = v.phy_rd;
        check($sformatf("v%0d mdc rises", idx), 64'(rises), 64'(32 + PRE_BIT));
        check($sformatf("v%0d mdio_out bits", idx), cap_out, exp_o);
        check($sformatf("v%0d mdio_oe bits", idx), cap_oe, exp_e);
        check($sformatf("v%0d first mdc rise cycle", idx), 64'(first_rise), 64'(1 + D));
        check($sformatf("v%0d oe fall cycle", idx), 64'(oe_fall), 64'(exp_fall));
        check($sformatf("v%0d busy fall cycle", idx), 64'(done_cyc), 64'(END_CYC));
        check($sformatf("v%0d data_rdy count", idx), 64'(rdy_cnt), v.is_read ? 64'd1 : 64'd0);
        if (v.is_read)
            check($sformatf("v%0d data_rdy cycle", idx), 64'(rdy_cyc), 64'(END_CYC));
        check($sformatf("v%0d rd_data", idx), 64'(bus.o_rd_data), 64'(exp_rd));
        check($sformatf("v%0d idle after", idx), {bus.o_busy, o_mdc, o_mdio_oe}, 3'b000);
    endtask

    initial begin
        int bad;
        int rdy_seen;
        n_cmp = 0; n_fail = 0; exp_rd = 16'h0000;
        vecs[0] = '{32'h509A_BEEF, 16'h0000, 1'b0, 1'b0, 32'h509A_BEEF, 32'hFFFF_FFFF};
        vecs[1] = '{32'h6082_0000, 16'hA5C3, 1'b0, 1'b1, 32'h6082_0000, 32'hFFFF_0000};
        vecs[2] = '{32'h5123_5678, 16'h0000, 1'b1, 1'b0, 32'h5123_5678, 32'hFFFF_FFFF};
        vecs[3] = '{32'h6FFE_FFFF, 16'h8001, 1'b1, 1'b1, 32'h6FFE_0000, 32'hFFFF_0000};

        i_reset = 1'b1; i_mdio_in = 1'b0;
        bus.i_mdio_start = 1'b0; bus.i_t_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {o_mdc, o_mdio_oe, o_mdio_out, bus.o_busy, bus.o_data_rdy}, 5'b0);
        check("reset rd_data", 64'(bus.o_rd_data), 64'h0);
        i_reset = 1'b0;

        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if ({o_mdc, o_mdio_oe, o_mdio_out, bus.o_busy, bus.o_data_rdy} !== 5'b0) bad++;
        end
        check("idle 100 cycles", 64'(bad), 64'd0);
        check("idle rd_data", 64'(bus.o_rd_data), 64'h0);

        for (int i = 0; i < 4; i++) begin
            run_frame(i, vecs[i]);
            @(negedge clk);
        end

        // Abort a read at cycle 70, then restart at cycle 80
        rdy_seen = 0;
        bus.i_mdio_start = 1'b1;
        bus.i_t_data     = vecs[1].t_data;
        @(posedge clk);
        #1;
        bus.i_mdio_start = 1'b0;
        for (int cyc = 1; cyc <= 69; cyc++) begin
            @(negedge clk);
            if (bus.o_data_rdy) rdy_seen++;
        end
        check("pre-abort busy", 64'(bus.o_busy), 64'd1);
        i_reset = 1'b1;
        @(negedge clk);
        check("abort outputs", {o_mdc, o_mdio_oe, o_mdio_out, bus.o_busy, bus.o_data_rdy}, 5'b0);
        check("abort rd_data", 64'(bus.o_rd_data), 64'h0);
        exp_rd = 16'h0000;
        i_reset = 1'b0;
        for (int cyc = 71; cyc <= 79; cyc++) begin
            @(negedge clk);
            if (bus.o_data_rdy) rdy_seen++;
        end
        check("abort no data_rdy", 64'(rdy_seen), 64'd0);
        run_frame(4, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
